// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl
//   Sequences one AES-128 encryption over the shared SubBytes, MixColumns and
//   key-expansion units. Holds the 128-bit state, applies AddRoundKey and
//   ShiftRows locally, and supervises every wait with a watchdog.
//
// Ports
//   clk, resetn          clock, synchronous active-low reset
//   start, pt_in         host start pulse (IDLE only) and plaintext
//   busy, done, ct_out   host status, one-cycle done pulse, ciphertext register
//   err                  one-cycle pulse on watchdog expiry
//   rk_req/rk_idx        round-key request and index, rk_ack/rk_data response
//   sbox_en/sbox_in      SubBytes request, sbox_done/sbox_out response
//   mix_en/mix_in        MixColumns request, mix_valid/mix_word column results
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start
// KEY    | round key requested; AddRoundKey on rk_ack
// SUB    | SubBytes running; ShiftRows applied on sbox_done
// MIX    | MixColumns running; four column words collected
// FIN    | ciphertext presented, done pulse
// ERR    | watchdog expired, err pulse
module aes_round_ctrl #(
  parameter int WDOG_CYCLES = 256,
  parameter int NROUNDS     = 10
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic [127:0] pt_in,
  output logic         busy,
  output logic         done,
  output logic [127:0] ct_out,
  output logic         err,
  output logic         rk_req,
  output logic [3:0]   rk_idx,
  input  logic         rk_ack,
  input  logic [127:0] rk_data,
  output logic         sbox_en,
  output logic [127:0] sbox_in,
  input  logic         sbox_done,
  input  logic [127:0] sbox_out,
  output logic         mix_en,
  output logic [127:0] mix_in,
  input  logic         mix_valid,
  input  logic [31:0]  mix_word
);

  localparam int         WW        = $clog2(WDOG_CYCLES + 1);
  localparam logic [WW-1:0] WDOG_LOAD = WW'(WDOG_CYCLES - 1);
  localparam logic [3:0] LAST      = 4'(NROUNDS);

  typedef enum logic [2:0] {
    S_IDLE, S_KEY, S_SUB, S_MIX, S_FIN, S_ERR
  } state_t;

  state_t         state, state_nxt;
  logic [127:0]   st;
  logic [3:0]     round;
  logic [1:0]     cnt;
  logic [31:0]    col0, col1, col2;
  logic [WW-1:0]  wdog;
  logic           wdog_tc;
  logic           in_wait;

  // Row r of the column-major state rotates left by r byte positions.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int rw = 0; rw < 4; rw++) begin
        r[127 - 8*(4*c + rw) -: 8] = s[127 - 8*(4*((c + rw) % 4) + rw) -: 8];
      end
    end
    return r;
  endfunction

  assign wdog_tc = (wdog == '0);
  assign in_wait = (state == S_KEY) || (state == S_SUB) || (state == S_MIX);
  assign rk_idx  = round;
  assign sbox_in = st;
  assign mix_in  = st;

  always_comb begin
    state_nxt = state;
    rk_req    = 1'b0;
    sbox_en   = 1'b0;
    mix_en    = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_KEY;
      S_KEY: begin
        rk_req = 1'b1;
        // a completing handshake takes priority over a simultaneous expiry
        if (rk_ack)       state_nxt = (round == LAST) ? S_FIN : S_SUB;
        else if (wdog_tc) state_nxt = S_ERR;
      end
      S_SUB: begin
        sbox_en = 1'b1;
        if (sbox_done)    state_nxt = (round < LAST) ? S_MIX : S_KEY;
        else if (wdog_tc) state_nxt = S_ERR;
      end
      S_MIX: begin
        mix_en = 1'b1;
        if (mix_valid && cnt == 2'd3) state_nxt = S_KEY;
        else if (wdog_tc)             state_nxt = S_ERR;
      end
      S_FIN: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      S_ERR: begin
        err       = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= S_IDLE;
      st     <= '0;
      round  <= '0;
      cnt    <= '0;
      col0   <= '0;
      col1   <= '0;
      col2   <= '0;
      wdog   <= WDOG_LOAD;
      busy   <= 1'b0;
      ct_out <= '0;
    end else begin
      state <= state_nxt;
      // down-counter reloads on every state entry and outside wait states
      if (!in_wait || state_nxt != state) wdog <= WDOG_LOAD;
      else if (!wdog_tc)                  wdog <= wdog - 1'b1;

      case (state)
        S_IDLE: if (start) begin
          st    <= pt_in;
          round <= '0;
          busy  <= 1'b1;
        end
        S_KEY: if (rk_ack) begin
          st <= st ^ rk_data;
          // loading ct_out here makes it valid during the done cycle
          if (round == LAST) ct_out <= st ^ rk_data;
          else               round  <= round + 1'b1;
        end
        S_SUB: if (sbox_done) st <= shift_rows(sbox_out);
        S_MIX: if (mix_valid) begin
          cnt <= cnt + 1'b1;
          case (cnt)
            2'd0:    col0 <= mix_word;
            2'd1:    col1 <= mix_word;
            2'd2:    col2 <= mix_word;
            default: st   <= {col0, col1, col2, mix_word};
          endcase
        end
        S_FIN, S_ERR: begin
          busy  <= 1'b0;
          round <= '0;
          cnt   <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
